// File: rtl/ipsxe_floating_point_apm_add_scheduler_v1_0.sv
// Round-robin scheduler sharing one APM post-adder (P = Z + sext(X)); results return in order after APM_LATENCY+1 cycles.
// Issue stalls (o_req_ready low) once queued plus in-flight results would fill the result FIFO.
module ipsxe_floating_point_apm_add_scheduler_v1_0 #(
    parameter int NUM_REQ     = 4,
    parameter int Z_WIDTH     = 10,
    parameter int X_WIDTH     = 2,
    parameter int APM_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*Z_WIDTH-1:0] i_req_z,
    input  logic [NUM_REQ*X_WIDTH-1:0] i_req_x,
    output logic [X_WIDTH-1:0]         o_apm_x,
    output logic [Z_WIDTH-1:0]         o_apm_z,
    input  logic [Z_WIDTH-1:0]         i_apm_p,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [ID_W-1:0]            o_rsp_id,
    output logic [Z_WIDTH-1:0]         o_rsp_data,
    output logic                       o_busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0]        credit_q, credit_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [ID_W+Z_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                    win_found;
    logic [ID_W-1:0]         win_id;
    logic [Z_WIDTH-1:0]      win_z;
    logic [X_WIDTH-1:0]      win_x;
    logic                    issue, push, pop, inflight;
    logic [ID_W-1:0]         push_id;
    int                      arb_dist, arb_best;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Winner is the valid requester with the smallest rotational distance from rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_z     = '0;
        win_x     = '0;
        arb_best  = NUM_REQ;
        arb_dist  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_dist = (k + NUM_REQ - int'(rr_ptr_q)) % NUM_REQ;
            if (i_req_valid[k] && (arb_dist < arb_best)) begin
                arb_best  = arb_dist;
                win_found = 1'b1;
                win_id    = ID_W'(k);
                win_z     = i_req_z[k*Z_WIDTH +: Z_WIDTH];
                win_x     = i_req_x[k*X_WIDTH +: X_WIDTH];
            end
        end
    end

    assign issue       = win_found && (credit_q != '0) && i_rst_n;
    assign o_req_ready = issue ? (NUM_REQ'(1) << win_id) : '0;
    assign o_apm_z     = issue ? win_z : '0;
    assign o_apm_x     = issue ? win_x : '0;

    assign o_rsp_valid = (cnt_q != '0);
    assign pop         = o_rsp_valid && i_rsp_ready;
    assign {o_rsp_id, o_rsp_data} = o_rsp_valid ? mem_q[rd_ptr_q] : '0;
    assign o_busy      = inflight || o_rsp_valid;

    if (APM_LATENCY == 0) begin : g_lat0
        assign push     = issue;
        assign push_id  = win_id;
        assign inflight = 1'b0;
    end else begin : g_lat1
        logic            tag_vld_q;
        logic [ID_W-1:0] tag_id_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                tag_vld_q <= 1'b0;
                tag_id_q  <= '0;
            end else begin
                tag_vld_q <= issue;
                tag_id_q  <= win_id;
            end
        end

        assign push     = tag_vld_q;
        assign push_id  = tag_id_q;
        assign inflight = tag_vld_q;
    end

    always_comb begin
        credit_d = credit_q;
        cnt_d    = cnt_q;
        if (issue && !pop) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (pop && !issue) begin
            credit_d = credit_q + CNT_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            credit_q <= CNT_W'(FIFO_DEPTH);
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible while cnt_q says they are valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {push_id, i_apm_p};
        end
    end

endmodule

// File: tb/tb_ipsxe_floating_point_apm_add_scheduler_v1_0.sv
// Two scheduler builds (latency 1 / depth 4 and latency 0 / depth 1) checked every cycle
// against a queue-based reference of the arbitration, credit and in-order result rules.
module tb_ipsxe_floating_point_apm_add_scheduler_v1_0;
    localparam int N  = 4;
    localparam int ZW = 10;
    localparam int XW = 2;
    localparam int NI = 2;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    valid   [NI];
    logic [N*ZW-1:0] zin     [NI];
    logic [N*XW-1:0] xin     [NI];
    logic            rsp_rdy [NI];
    logic [N-1:0]    ready   [NI];
    logic [XW-1:0]   apm_x   [NI];
    logic [ZW-1:0]   apm_z   [NI];
    logic [ZW-1:0]   apm_p   [NI];
    logic            rsp_vld [NI];
    logic [1:0]      rsp_id  [NI];
    logic [ZW-1:0]   rsp_dat [NI];
    logic            busy    [NI];
    logic [N-1:0]    acc     [NI];
    int              total = 0;
    int              bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // (Z + signed X) mod 2^ZW using plain integer arithmetic.
    function automatic int add_ref(input int z, input int x);
        int sx;
        sx = (x >= (1 << (XW - 1))) ? x - (1 << XW) : x;
        return (z + sx) & ((1 << ZW) - 1);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 0;
        localparam int DEP = (g == 0) ? 4 : 1;

        ipsxe_floating_point_apm_add_scheduler_v1_0 #(
            .NUM_REQ(N), .Z_WIDTH(ZW), .X_WIDTH(XW), .APM_LATENCY(LAT), .FIFO_DEPTH(DEP)
        ) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_req_valid(valid[g]),
            .o_req_ready(ready[g]),
            .i_req_z    (zin[g]),
            .i_req_x    (xin[g]),
            .o_apm_x    (apm_x[g]),
            .o_apm_z    (apm_z[g]),
            .i_apm_p    (apm_p[g]),
            .o_rsp_valid(rsp_vld[g]),
            .i_rsp_ready(rsp_rdy[g]),
            .o_rsp_id   (rsp_id[g]),
            .o_rsp_data (rsp_dat[g]),
            .o_busy     (busy[g])
        );

        if (LAT == 1) begin : g_apm
            logic [ZW-1:0] z_r;
            logic [XW-1:0] x_r;
            always @(posedge clk) begin
                z_r <= apm_z[g];
                x_r <= apm_x[g];
            end
            assign apm_p[g] = ZW'(add_ref(int'(z_r), int'(x_r)));
        end else begin : g_apm
            assign apm_p[g] = ZW'(add_ref(int'(apm_z[g]), int'(apm_x[g])));
        end

        int credits = DEP;
        int rr = 0;
        int win, zv, xv, idx;
        int p_id[$], p_dat[$], f_id[$], f_dat[$];

        always @(negedge clk) begin
            if (!rst_n) begin
                credits = DEP;
                rr = 0;
                p_id.delete(); p_dat.delete(); f_id.delete(); f_dat.delete();
                chk($sformatf("g%0d_rst_ready", g), ready[g], 0);
                chk($sformatf("g%0d_rst_apm_z", g), apm_z[g], 0);
                chk($sformatf("g%0d_rst_apm_x", g), apm_x[g], 0);
                chk($sformatf("g%0d_rst_rsp_valid", g), rsp_vld[g], 0);
                chk($sformatf("g%0d_rst_rsp_id", g), rsp_id[g], 0);
                chk($sformatf("g%0d_rst_rsp_data", g), rsp_dat[g], 0);
                chk($sformatf("g%0d_rst_busy", g), busy[g], 0);
            end else begin
                win = -1;
                if (credits > 0) begin
                    for (int i = 0; i < N; i++) begin
                        idx = (rr + i) % N;
                        if (win < 0 && valid[g][idx]) win = idx;
                    end
                end
                zv = (win < 0) ? 0 : int'(zin[g] >> (win * ZW)) & ((1 << ZW) - 1);
                xv = (win < 0) ? 0 : int'(xin[g] >> (win * XW)) & ((1 << XW) - 1);
                chk($sformatf("g%0d_ready", g), ready[g], (win < 0) ? 0 : (1 << win));
                chk($sformatf("g%0d_apm_z", g), apm_z[g], zv);
                chk($sformatf("g%0d_apm_x", g), apm_x[g], xv);
                chk($sformatf("g%0d_rsp_valid", g), rsp_vld[g], f_id.size() > 0);
                chk($sformatf("g%0d_rsp_id", g), rsp_id[g], (f_id.size() > 0) ? f_id[0] : 0);
                chk($sformatf("g%0d_rsp_data", g), rsp_dat[g], (f_id.size() > 0) ? f_dat[0] : 0);
                chk($sformatf("g%0d_busy", g), busy[g], (p_id.size() + f_id.size()) > 0);

                if (f_id.size() > 0 && rsp_rdy[g]) begin
                    void'(f_id.pop_front());
                    void'(f_dat.pop_front());
                    credits++;
                end
                while (p_id.size() > 0) begin
                    f_id.push_back(p_id.pop_front());
                    f_dat.push_back(p_dat.pop_front());
                end
                if (win >= 0) begin
                    if (LAT == 0) begin
                        f_id.push_back(win);
                        f_dat.push_back(add_ref(zv, xv));
                    end else begin
                        p_id.push_back(win);
                        p_dat.push_back(add_ref(zv, xv));
                    end
                    credits--;
                    rr = (win + 1) % N;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input int gi, input int k, input int z, input int x, input int expd);
        int lat = (gi == 0) ? 1 : 0;
        valid[gi] = '0;
        valid[gi][k] = 1'b1;
        zin[gi][k*ZW +: ZW] = z[ZW-1:0];
        xin[gi][k*XW +: XW] = x[XW-1:0];
        rsp_rdy[gi] = 1'b1;
        @(negedge clk);
        chk("single_grant", ready[gi], 1 << k);
        step();
        valid[gi] = '0;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            chk("single_early", rsp_vld[gi], 0);
            step();
        end
        @(negedge clk);
        chk("single_valid", rsp_vld[gi], 1);
        chk("single_id", rsp_id[gi], k);
        chk("single_data", rsp_dat[gi], expd);
        step();
    endtask

    task automatic drain(input int cycles);
        for (int gi = 0; gi < NI; gi++) begin
            valid[gi] = '0;
            rsp_rdy[gi] = 1'b1;
        end
        repeat (cycles) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nis;
        int pv;
        int pr;
        for (int gi = 0; gi < NI; gi++) begin
            valid[gi] = '1;
            zin[gi] = '0;
            xin[gi] = '0;
            rsp_rdy[gi] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_gated", ready[0], 0);
        chk("rst_busy", busy[0], 0);
        step();
        valid[0] = '0;
        valid[1] = '0;
        rst_n = 1'b1;

        single(0, 2, 'h0F0, 1, 'h0F1);
        single(0, 0, 'h3FF, 1, 'h000);
        single(0, 1, 'h000, 3, 'h3FF);
        single(0, 3, 'h200, 2, 'h1FE);
        single(1, 1, 'h155, 2, 'h153);

        // Fairness: all requesters on, consumer always ready.
        valid[0] = '1;
        zin[0] = {$urandom, $urandom};
        xin[0] = 8'($urandom);
        rsp_rdy[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("rr_grant", ready[0], 1 << (c % 4));
            if (c >= 2) begin
                chk("rr_rsp_valid", rsp_vld[0], 1);
                chk("rr_rsp_id", rsp_id[0], (c - 2) % 4);
            end
            step();
        end
        drain(4);

        // Backpressure: credits run out after exactly DEPTH issues.
        valid[0] = '1;
        rsp_rdy[0] = 1'b0;
        nis = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            nis += $countones(ready[0]);
            step();
        end
        chk("bp_issues", nis, 4);
        rsp_rdy[0] = 1'b1;
        @(negedge clk);
        chk("bp_pop_cycle_ready", ready[0], 0);
        chk("bp_pop_cycle_valid", rsp_vld[0], 1);
        step();
        rsp_rdy[0] = 1'b0;
        @(negedge clk);
        chk("bp_one_issue", ready[0], 4'b0001);
        step();
        @(negedge clk);
        chk("bp_stalled_again", ready[0], 0);
        step();
        drain(8);

        // Reset with results queued and in flight.
        valid[0] = '1;
        rsp_rdy[0] = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("mid_busy_before_rst", busy[0], 1);
        step();
        #1;
        rst_n = 1'b0;
        valid[0] = 4'b0110;
        @(negedge clk);
        chk("mid_rst_busy", busy[0], 0);
        chk("mid_rst_rsp_valid", rsp_vld[0], 0);
        chk("mid_rst_ready", ready[0], 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", ready[0], 4'b0010);
        step();
        drain(6);

        // Zero-latency build with a toggling consumer: never issue while a result is held.
        valid[1] = '1;
        for (int c = 0; c < 16; c++) begin
            rsp_rdy[1] = c[0];
            @(negedge clk);
            chk("z_no_overlap", (ready[1] != 0) && rsp_vld[1], 0);
            step();
        end
        drain(4);

        // Random traffic on both builds; requesters mostly hold until accepted.
        for (int c = 0; c < 3000; c++) begin
            pv = 30 + ((c / 500) * 23) % 70;
            pr = 20 + ((c / 500) * 37) % 81;
            @(negedge clk);
            for (int gi = 0; gi < NI; gi++) acc[gi] = valid[gi] & ready[gi];
            step();
            for (int gi = 0; gi < NI; gi++) begin
                for (int k = 0; k < N; k++) begin
                    if (!valid[gi][k] || acc[gi][k] || ($urandom_range(15) == 0)) begin
                        valid[gi][k] = ($urandom_range(99) < pv);
                        zin[gi][k*ZW +: ZW] = ZW'($urandom);
                        xin[gi][k*XW +: XW] = XW'($urandom);
                    end
                end
                rsp_rdy[gi] = ($urandom_range(99) < pr);
            end
        end
        drain(10);
        @(negedge clk);
        chk("end_idle_g0", busy[0], 0);
        chk("end_idle_g1", busy[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
